// File: rtl/register_file.sv
// RV32 integer register file: x1..x31 are 32-bit flops, x0 reads as zero.
// Two combinational read ports, one synchronous write port, async active-high reset.
module register_file (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WRITE,
    input  logic [4:0]  inaddr_a,
    input  logic [4:0]  inaddr_b,
    input  logic [4:0]  inaddr_w,
    input  logic [31:0] indata_w,
    output logic [31:0] outdata_a,
    output logic [31:0] outdata_b
);

    logic [31:0] regs_q [1:31];
    logic [31:0] regs_d [1:31];

    // x0 has no storage, so a write addressed to 0 matches no entry and is dropped.
    always_comb begin
        for (int i = 1; i < 32; i++) begin
            regs_d[i] = regs_q[i];
            if (WRITE && (inaddr_w == 5'(i))) begin
                regs_d[i] = indata_w;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Reads see committed storage only; a pending write is not forwarded.
    always_comb begin
        outdata_a = 32'h0;
        outdata_b = 32'h0;
        for (int i = 1; i < 32; i++) begin
            if (inaddr_a == 5'(i)) begin
                outdata_a = regs_q[i];
            end
            if (inaddr_b == 5'(i)) begin
                outdata_b = regs_q[i];
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed table, sweeps, random traffic
// against an array model, and asynchronous reset corner cases.
module tb_register_file;

    logic        CLK;
    logic        RST;
    logic        WRITE;
    logic [4:0]  inaddr_a;
    logic [4:0]  inaddr_b;
    logic [4:0]  inaddr_w;
    logic [31:0] indata_w;
    logic [31:0] outdata_a;
    logic [31:0] outdata_b;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [32];

    typedef struct {
        logic        w;
        logic [4:0]  aw;
        logic [31:0] dw;
        logic [4:0]  aa;
        logic [4:0]  ab;
        logic [31:0] exp_a_pre;
        logic [31:0] exp_a_post;
        logic [31:0] exp_b_post;
    } vec_t;

    vec_t vecs [9];

    register_file dut (
        .CLK       (CLK),
        .RST       (RST),
        .WRITE     (WRITE),
        .inaddr_a  (inaddr_a),
        .inaddr_b  (inaddr_b),
        .inaddr_w  (inaddr_w),
        .indata_w  (indata_w),
        .outdata_a (outdata_a),
        .outdata_b (outdata_b)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_write(input logic w, input logic [4:0] aw, input logic [31:0] dw);
        if (w && aw != 5'd0) model[aw] = dw;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    // One write-port cycle: drive on the falling edge, check old values before the
    // rising edge, then check both ports just after it.
    task automatic do_cycle(input logic w, input logic [4:0] aw, input logic [31:0] dw,
                            input logic [4:0] aa, input logic [4:0] ab, input string name);
        @(negedge CLK);
        WRITE = w; inaddr_w = aw; indata_w = dw; inaddr_a = aa; inaddr_b = ab;
        #1;
        check({name, "_a_pre"}, outdata_a, model[aa]);
        check({name, "_b_pre"}, outdata_b, model[ab]);
        @(posedge CLK);
        model_write(w, aw, dw);
        #1;
        check({name, "_a_post"}, outdata_a, model[aa]);
        check({name, "_b_post"}, outdata_b, model[ab]);
    endtask

    task automatic read_both(input logic [4:0] aa, input logic [4:0] ab,
                             input logic [31:0] ea, input logic [31:0] eb, input string name);
        inaddr_a = aa; inaddr_b = ab;
        #1;
        check({name, "_a"}, outdata_a, ea);
        check({name, "_b"}, outdata_b, eb);
    endtask

    initial begin
        RST = 1'b1; WRITE = 1'b0; inaddr_a = '0; inaddr_b = '0; inaddr_w = '0; indata_w = '0;
        model_clear();

        vecs[0] = '{1'b1, 5'd1,  32'h0000ffff, 5'd1,  5'd0,  32'h0,        32'h0000ffff, 32'h0};
        vecs[1] = '{1'b1, 5'd1,  32'h0000ffff, 5'd1,  5'd1,  32'h0000ffff, 32'h0000ffff, 32'h0000ffff};
        vecs[2] = '{1'b1, 5'd0,  32'hdeadbeef, 5'd0,  5'd1,  32'h0,        32'h0,        32'h0000ffff};
        vecs[3] = '{1'b1, 5'd5,  32'h11111111, 5'd5,  5'd0,  32'h0,        32'h11111111, 32'h0};
        vecs[4] = '{1'b0, 5'd5,  32'h12345678, 5'd5,  5'd5,  32'h11111111, 32'h11111111, 32'h11111111};
        vecs[5] = '{1'b0, 5'd5,  32'h12345678, 5'd5,  5'd5,  32'h11111111, 32'h11111111, 32'h11111111};
        vecs[6] = '{1'b1, 5'd9,  32'haaaa0001, 5'd9,  5'd1,  32'h0,        32'haaaa0001, 32'h0000ffff};
        vecs[7] = '{1'b1, 5'd9,  32'haaaa0002, 5'd9,  5'd9,  32'haaaa0001, 32'haaaa0002, 32'haaaa0002};
        vecs[8] = '{1'b1, 5'd31, 32'hffffffff, 5'd31, 5'd30, 32'h0,        32'hffffffff, 32'h0};

        // Reset pulse with clock running, then sweep both ports.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 32; i++) read_both(5'(i), 5'(31 - i), 32'h0, 32'h0, "reset_sweep");

        // Directed table.
        for (int k = 0; k < 9; k++) begin
            @(negedge CLK);
            WRITE = vecs[k].w; inaddr_w = vecs[k].aw; indata_w = vecs[k].dw;
            inaddr_a = vecs[k].aa; inaddr_b = vecs[k].ab;
            #1;
            check($sformatf("vec%0d_a_pre", k), outdata_a, vecs[k].exp_a_pre);
            @(posedge CLK);
            model_write(vecs[k].w, vecs[k].aw, vecs[k].dw);
            #1;
            check($sformatf("vec%0d_a_post", k), outdata_a, vecs[k].exp_a_post);
            check($sformatf("vec%0d_b_post", k), outdata_b, vecs[k].exp_b_post);
        end

        // Full sweep with distinct values, read back in several orders.
        for (int i = 1; i < 32; i++) do_cycle(1'b1, 5'(i), 32'h1000_0000 + i, 5'(i), 5'(i), "sweep_wr");
        @(negedge CLK);
        WRITE = 1'b0;
        for (int i = 0; i < 32; i++) begin
            int ra, rb;
            ra = (i * 7) % 32;
            rb = (i * 13 + 5) % 32;
            read_both(5'(ra), 5'(rb),
                      (ra == 0) ? 32'h0 : 32'h1000_0000 + ra,
                      (rb == 0) ? 32'h0 : 32'h1000_0000 + rb, "sweep_rd");
        end

        // Randomized traffic against the array model.
        for (int n = 0; n < 300; n++) begin
            do_cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                     5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "rand");
        end

        // Async reset between edges.
        do_cycle(1'b1, 5'd7, 32'hcafef00d, 5'd7, 5'd7, "pre_rst_wr");
        @(negedge CLK);
        WRITE = 1'b0; inaddr_b = 5'd7; inaddr_a = 5'd9;
        #1;
        check("mid_b_before_rst", outdata_b, 32'hcafef00d);
        #2;
        RST = 1'b1;
        #1;
        model_clear();
        check("mid_b_after_rst", outdata_b, 32'h0);
        check("mid_a_after_rst", outdata_a, 32'h0);
        WRITE = 1'b1; inaddr_w = 5'd7; indata_w = 32'h0badf00d;
        @(posedge CLK);
        #1;
        check("rst_blocks_write", outdata_b, 32'h0);
        @(negedge CLK);
        RST = 1'b0; WRITE = 1'b0;
        #1;
        check("post_rst_b", outdata_b, 32'h0);
        do_cycle(1'b1, 5'd7, 32'h5a5a_0007, 5'd7, 5'd0, "first_wr_after_rst");
        for (int i = 0; i < 32; i++) begin
            read_both(5'(i), 5'(i), (i == 7) ? 32'h5a5a_0007 : 32'h0,
                      (i == 7) ? 32'h5a5a_0007 : 32'h0, "post_rst_sweep");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
